// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: shared types and constants for the USB transmit token path.
// Holds the serializer state encoding, the CRC5 constants and the single
// LFSR step used by the CRC5 generator.

package usb_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PID  = 2'd1,
        DATA = 2'd2,
        CRC  = 2'd3
    } tx_state_e;

    localparam logic [4:0] CRC5_INIT     = 5'b11111;
    localparam logic [4:0] CRC5_RESIDUAL = 5'b01100;
    localparam int         PID_W         = 8;

    // One serial step of the USB CRC5 LFSR (x^5 + x^2 + 1).
    function automatic logic [4:0] crc5_step(input logic [4:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[4];
        return {crc[3], crc[2], crc[1] ^ fb, crc[0], fb};
    endfunction

endpackage

// File: rtl/usb_tx_crc5_gen.sv
// usb_tx_crc5_gen: 5-bit CRC register for the token serializer.
// load restarts it at INIT; shift either folds din into the LFSR or, in
// out_mode, moves the finished remainder towards bit 4 for transmission.

module usb_tx_crc5_gen
    import usb_tx_pkg::*;
#(
    parameter logic [4:0] INIT = CRC5_INIT
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       load,
    input  logic       shift,
    input  logic       din,
    input  logic       out_mode,
    output logic [4:0] crc
);

    logic [4:0] crc_d;

    // Next CRC value: load wins, then accumulate or shift-out.
    always_comb begin
        crc_d = crc;
        if (load) begin
            crc_d = INIT;
        end else if (shift) begin
            crc_d = out_mode ? {crc[3:0], 1'b0} : crc5_step(crc, din);
        end
    end

    // CRC register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            crc <= INIT;
        end else begin
            crc <= crc_d;
        end
    end

endmodule

// File: rtl/usb_tx_token_crc5.sv
// usb_tx_token_crc5: serializes an 11-bit USB token payload LSB-first, one
// bit per shift_enable strobe, then appends the complemented CRC5 MSB-first.
// Build option: define USB_TX_PID_EN to send the 8-bit {~pid, pid} field
// (LSB-first, outside the CRC) ahead of the payload.

module usb_tx_token_crc5
    import usb_tx_pkg::*;
#(
    parameter int         DATA_W   = 11,
    parameter logic [4:0] CRC_INIT = CRC5_INIT
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              tok_valid,
    output logic              tok_ready,
    input  logic [DATA_W-1:0] tok_data,
    input  logic [3:0]        tok_pid,
    input  logic              shift_enable,
    input  logic              tx_abort,
    output logic              tx_bit,
    output logic              tx_active,
    output logic              tx_done
);

`ifdef USB_TX_PID_EN
    localparam int SH_W = DATA_W + PID_W;
`else
    localparam int SH_W = DATA_W;
`endif
    localparam int CNT_RAW = $clog2(DATA_W + 1);
    localparam int CNT_W   = (CNT_RAW > 3) ? CNT_RAW : 3;

    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(4);
`ifdef USB_TX_PID_EN
    localparam logic [CNT_W-1:0] PID_LAST  = CNT_W'(PID_W - 1);
`endif

    tx_state_e        state, state_d;
    logic [SH_W-1:0]  shreg, shreg_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             tx_bit_d;
    logic             tx_done_d;
    logic             accept;
    logic             crc_load;
    logic             crc_shift;
    logic             crc_out_mode;
    logic [4:0]       crc;

`ifndef USB_TX_PID_EN
    logic unused_pid;
    assign unused_pid = ^tok_pid;
`endif

    // Ready only in IDLE and not during the tx_done cycle, so a new payload
    // lands the cycle after tx_done.
    assign tok_ready    = (state == IDLE) && !tx_done;
    assign accept       = tok_valid && tok_ready;
    assign tx_active    = (state != IDLE);
    assign crc_out_mode = (state == CRC);

    usb_tx_crc5_gen #(
        .INIT (CRC_INIT)
    ) u_crc (
        .clk      (clk),
        .n_rst    (n_rst),
        .load     (crc_load),
        .shift    (crc_shift),
        .din      (shreg[0]),
        .out_mode (crc_out_mode),
        .crc      (crc)
    );

    // Next-state, datapath and output decode; abort overrides everything.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d   = state;
        shreg_d   = shreg;
        cnt_d     = cnt;
        tx_bit_d  = tx_bit;
        tx_done_d = 1'b0;
        crc_load  = 1'b0;
        crc_shift = 1'b0;

        if (tx_abort) begin
            state_d  = IDLE;
            cnt_d    = '0;
            tx_bit_d = 1'b1;
            crc_load = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    // A strobe in the acceptance cycle is deliberately ignored.
                    if (accept) begin
`ifdef USB_TX_PID_EN
                        shreg_d  = {tok_data, ~tok_pid, tok_pid};
                        state_d  = PID;
                        tx_bit_d = tok_pid[0];
`else
                        shreg_d  = tok_data;
                        state_d  = DATA;
                        tx_bit_d = tok_data[0];
`endif
                        cnt_d    = '0;
                        crc_load = 1'b1;
                    end
                end
`ifdef USB_TX_PID_EN
                PID: begin
                    if (shift_enable) begin
                        shreg_d  = shreg >> 1;
                        tx_bit_d = shreg[1];
                        if (cnt == PID_LAST) begin
                            cnt_d   = '0;
                            state_d = DATA;
                        end else begin
                            cnt_d = cnt + 1'b1;
                        end
                    end
                end
`endif
                DATA: begin
                    if (shift_enable) begin
                        crc_shift = 1'b1;
                        shreg_d   = shreg >> 1;
                        if (cnt == DATA_LAST) begin
                            cnt_d    = '0;
                            state_d  = CRC;
                            // Bit 4 after the LFSR step is the current bit 3.
                            tx_bit_d = ~crc[3];
                        end else begin
                            cnt_d    = cnt + 1'b1;
                            tx_bit_d = shreg[1];
                        end
                    end
                end
                CRC: begin
                    if (shift_enable) begin
                        crc_shift = 1'b1;
                        if (cnt == CRC_LAST) begin
                            cnt_d     = '0;
                            state_d   = IDLE;
                            tx_bit_d  = 1'b1;
                            tx_done_d = 1'b1;
                        end else begin
                            cnt_d    = cnt + 1'b1;
                            tx_bit_d = ~crc[3];
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block ordering.
            state <= state_d;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            // NOTE: the shift register is reset too; its contents are dead in
            // IDLE, but a defined value keeps reset behaviour deterministic.
            shreg   <= '0;
            cnt     <= '0;
            tx_bit  <= 1'b1;
            tx_done <= 1'b0;
        end else begin
            shreg   <= shreg_d;
            cnt     <= cnt_d;
            tx_bit  <= tx_bit_d;
            tx_done <= tx_done_d;
        end
    end

endmodule

// File: tb/tb_usb_tx_token_crc5.sv
// tb_usb_tx_token_crc5: directed vectors with hand-computed CRC fields,
// handshake / abort / mid-packet reset sequences and a random loopback
// through a receive-side CRC5 residual check.

module tb_usb_tx_token_crc5;

`ifdef USB_TX_PID_EN
    localparam int OFF = 8;
`else
    localparam int OFF = 0;
`endif
    localparam int PKT_LEN = OFF + 16;

    logic        clk;
    logic        n_rst;
    logic        tok_valid;
    logic        tok_ready;
    logic [10:0] tok_data;
    logic [3:0]  tok_pid;
    logic        shift_enable;
    logic        tx_abort;
    logic        tx_bit;
    logic        tx_active;
    logic        tx_done;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    usb_tx_token_crc5 dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .tok_valid    (tok_valid),
        .tok_ready    (tok_ready),
        .tok_data     (tok_data),
        .tok_pid      (tok_pid),
        .shift_enable (shift_enable),
        .tx_abort     (tx_abort),
        .tx_bit       (tx_bit),
        .tx_active    (tx_active),
        .tx_done      (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (tx_done === 1'b1) done_cnt++;

    initial begin
        #900000;
        $display("FAIL watchdog expired: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Offer one token at a negedge; on return the token has been accepted.
    task automatic start_packet(input string tag, input logic [10:0] data,
                                input logic [3:0] pid, input logic se_at_accept);
        @(negedge clk);
        check({tag, "_ready_idle"}, tok_ready, 1);
        tok_data     = data;
        tok_pid      = pid;
        tok_valid    = 1'b1;
        shift_enable = se_at_accept;
        @(negedge clk);
        tok_valid    = 1'b0;
        shift_enable = 1'b0;
        check({tag, "_active"}, tx_active, 1);
        check({tag, "_ready_busy"}, tok_ready, 0);
`ifdef USB_TX_PID_EN
        check({tag, "_first_bit"}, tx_bit, pid[0]);
`else
        check({tag, "_first_bit"}, tx_bit, data[0]);
`endif
    endtask

    // Issue n strobes gap cycles apart, capturing the bit on the line at each.
    task automatic shift_bits(input int n, input int gap, output logic [31:0] bits);
        bits = '0;
        for (int i = 0; i < n; i++) begin
            bits[i]      = tx_bit;
            shift_enable = 1'b1;
            @(negedge clk);
            shift_enable = 1'b0;
            if (i != n - 1) repeat (gap - 1) @(negedge clk);
        end
    endtask

    // Called at the first negedge after the last strobe of a full packet.
    task automatic end_checks(input string tag);
        check({tag, "_done"}, tx_done, 1);
        check({tag, "_idle_bit"}, tx_bit, 1);
        check({tag, "_inactive"}, tx_active, 0);
        check({tag, "_ready_in_done"}, tok_ready, 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, tx_done, 0);
        check({tag, "_ready_after"}, tok_ready, 1);
    endtask

    function automatic logic [4:0] crc_field(input logic [31:0] b);
        return {b[OFF+11], b[OFF+12], b[OFF+13], b[OFF+14], b[OFF+15]};
    endfunction

    // Receive-side checker: LFSR over payload plus CRC field as received.
    function automatic logic [4:0] rx_residual(input logic [31:0] b);
        logic [4:0] c;
        logic       fb;
        c = 5'b11111;
        for (int i = OFF; i < OFF + 16; i++) begin
            fb = b[i] ^ c[4];
            c  = {c[3], c[2], c[1] ^ fb, c[0], fb};
        end
        return c;
    endfunction

    typedef struct {
        logic [10:0] data;
        logic [3:0]  pid;
        int          gap;
        logic        se_acc;
        logic [4:0]  field;   // CRC bits in transmit order, first sent = MSB
    } vec_t;

    vec_t        vecs[4];
    logic [31:0] bits;
    int          d0;
    int          accepts;
    int          dones;
    int          first_done;
    logic [10:0] rdata;
    logic [3:0]  rpid;

    initial begin
        // Hand-computed from x^5+x^2+1, init 11111, complement, MSB first.
        vecs[0] = '{11'h000, 4'b1001, 4, 1'b0, 5'b01000};
        vecs[1] = '{11'h7FF, 4'b1001, 1, 1'b1, 5'b00010};
        vecs[2] = '{11'h001, 4'b0101, 3, 1'b0, 5'b10111};
        vecs[3] = '{11'h000, 4'b1001, 1, 1'b0, 5'b01000};

        n_rst        = 1'b0;
        tok_valid    = 1'b0;
        tok_data     = '0;
        tok_pid      = '0;
        shift_enable = 1'b0;
        tx_abort     = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_ready", tok_ready, 1);
        check("rst_bit", tx_bit, 1);
        check("rst_active", tx_active, 0);
        check("rst_done", tx_done, 0);
        n_rst = 1'b1;

        // Strobes in IDLE do nothing.
        shift_enable = 1'b1;
        repeat (3) @(negedge clk);
        shift_enable = 1'b0;
        check("idle_se_bit", tx_bit, 1);
        check("idle_se_active", tx_active, 0);

        // Directed vectors.
        for (int i = 0; i < 4; i++) begin
            start_packet($sformatf("vec%0d", i), vecs[i].data, vecs[i].pid, vecs[i].se_acc);
            shift_bits(PKT_LEN, vecs[i].gap, bits);
`ifdef USB_TX_PID_EN
            check($sformatf("vec%0d_pid", i), bits[7:0], {~vecs[i].pid, vecs[i].pid});
`endif
            check($sformatf("vec%0d_payload", i), bits[OFF +: 11], vecs[i].data);
            check($sformatf("vec%0d_crc", i), crc_field(bits), vecs[i].field);
            end_checks($sformatf("vec%0d", i));
        end

        // Handshake: valid held high, strobe every cycle (also on acceptance).
        accepts    = 0;
        dones      = 0;
        first_done = -1;
        tok_data     = 11'h7FF;
        tok_valid    = 1'b1;
        shift_enable = 1'b1;
        for (int k = 0; k < 3 * (PKT_LEN + 2); k++) begin
            @(negedge clk);
            if (tok_ready) accepts++;
            if (tx_done) begin
                dones++;
                if (first_done < 0) first_done = k;
            end
        end
        tok_valid    = 1'b0;
        shift_enable = 1'b0;
        check("hs_accepts", accepts, 3);
        check("hs_dones", dones, 3);
        check("hs_first_done", first_done, PKT_LEN);
        @(negedge clk);

        // Abort after two CRC bits.
        start_packet("abort", 11'h000, 4'b1001, 1'b0);
        shift_bits(OFF + 13, 2, bits);
        check("abort_crc_bits", {bits[OFF+11], bits[OFF+12]}, 2'b01);
        #1 d0 = done_cnt;
        tx_abort = 1'b1;
        @(negedge clk);
        tx_abort = 1'b0;
        check("abort_active", tx_active, 0);
        check("abort_bit", tx_bit, 1);
        check("abort_ready", tok_ready, 1);
        check("abort_done", tx_done, 0);
        shift_enable = 1'b1;
        repeat (6) @(negedge clk);
        shift_enable = 1'b0;
        #1;
        check("abort_no_done", done_cnt, d0);
        check("abort_still_idle", tx_active, 0);
        start_packet("post_abort", 11'h000, 4'b1001, 1'b0);
        shift_bits(PKT_LEN, 2, bits);
        check("post_abort_crc", crc_field(bits), 5'b01000);
        end_checks("post_abort");

        // Asynchronous reset while DATA bit 5 is on the line.
        start_packet("mid_rst", 11'h7FF, 4'b1001, 1'b0);
        shift_bits(OFF + 5, 3, bits);
        check("mid_rst_bit_before", tx_active, 1);
        #2 n_rst = 1'b0;
        #1;
        check("mid_rst_ready", tok_ready, 1);
        check("mid_rst_bit", tx_bit, 1);
        check("mid_rst_active", tx_active, 0);
        @(negedge clk);
        n_rst = 1'b1;
        start_packet("post_rst", 11'h001, 4'b0101, 1'b0);
        shift_bits(PKT_LEN, 1, bits);
        check("post_rst_payload", bits[OFF +: 11], 11'h001);
        check("post_rst_crc", crc_field(bits), 5'b10111);
        end_checks("post_rst");

        // Random loopback through the receive-side residual check.
        #1 d0 = done_cnt;
        for (int p = 0; p < 200; p++) begin
            rdata = 11'($urandom_range(0, 2047));
            rpid  = 4'($urandom_range(0, 15));
            start_packet("lb", rdata, rpid, 1'($urandom_range(0, 1)));
            shift_bits(PKT_LEN, $urandom_range(1, 2), bits);
            check($sformatf("lb%0d_payload", p), bits[OFF +: 11], rdata);
            check($sformatf("lb%0d_residual", p), rx_residual(bits), 5'b01100);
            check($sformatf("lb%0d_done", p), tx_done, 1);
            @(negedge clk);
        end
        #1;
        check("lb_done_count", done_cnt - d0, 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
